// File: rtl/fpu_sched_pkg.sv
// Shared types and defaults for the FPU writeback slot scheduler:
// op class encoding, reservation entry layout and default pipe latencies.
package fpu_sched_pkg;

  localparam int TAG_MAX_W     = 16;
  localparam int DEF_TAG_W     = 6;
  localparam int DEF_FMA_LAT   = 4;
  localparam int DEF_FPMU_LAT  = 2;
  localparam int DEF_IFPU_LAT  = 2;
  localparam int DEF_FPIU_LAT  = 1;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_FMA  = 3'd1,
    CLS_FPMU = 3'd2,
    CLS_IFPU = 3'd3,
    CLS_FPIU = 3'd4
  } fpu_class_e;

  // valid is kept as the MSB so a generic shifter can find it without the type
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [1:0]           type_tag;
    logic                 wflags;
  } res_entry_t;

  function automatic fpu_class_e sel_class(
    input logic fma,
    input logic fastpipe,
    input logic fromint,
    input logic toint
  );
    fpu_class_e cls;
    if (fma) begin
      cls = CLS_FMA;
    end else if (fastpipe) begin
      cls = CLS_FPMU;
    end else if (fromint) begin
      cls = CLS_IFPU;
    end else if (toint) begin
      cls = CLS_FPIU;
    end else begin
      cls = CLS_NONE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/wb_res_shifter.sv
// Writeback reservation shift register: entry i retires i+1 cycles from now.
// The MSB of every entry is its valid flag.
module wb_res_shifter #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             kill,
  input  logic             in_en,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [W-1:0]     in_entry,
  input  logic [IDX_W-1:0] query_idx,
  output logic             query_busy,
  output logic [W-1:0]     head,
  output logic             any_valid
);

  logic [W-1:0] res_r     [DEPTH];
  logic [W-1:0] shifted_s [DEPTH];
  logic [W-1:0] res_nxt_s [DEPTH];

  // Post-shift view: every entry moves one step closer to writeback
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted_s[i] = res_r[i + 1];
    end
    shifted_s[DEPTH - 1] = {W{1'b0}};
  end

  // Drop the accepted op into its slot on top of the shifted view
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      res_nxt_s[i] = (in_en && (in_idx == IDX_W'(i))) ? in_entry : shifted_s[i];
    end
  end

  // Occupancy summary across all entries
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | res_r[i][W-1];
    end
  end

  assign query_busy = shifted_s[query_idx][W-1];
  assign head       = res_r[0];

  // Reservation storage; kill and reset wipe every in-flight op
  always_ff @(posedge clock) begin
    if (reset || kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_r[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        res_r[i] <= res_nxt_s[i];
      end
    end
  end

endmodule

// File: rtl/fpu_wb_slot_scheduler.sv
// Issues decoded FPU ops into fixed-latency classes, reserving the FP or INT
// writeback slot up front so the two writeback ports never see a collision.
module fpu_wb_slot_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int TAG_W    = DEF_TAG_W,
  parameter int FMA_LAT  = DEF_FMA_LAT,
  parameter int FPMU_LAT = DEF_FPMU_LAT,
  parameter int IFPU_LAT = DEF_IFPU_LAT,
  parameter int FPIU_LAT = DEF_FPIU_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_kill,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [TAG_W-1:0] io_in_tag,
  input  logic [1:0]       io_in_typeTagOut,
  input  logic             io_in_wflags,
  input  logic             io_in_fma,
  input  logic             io_in_fastpipe,
  input  logic             io_in_fromint,
  input  logic             io_in_toint,
  output logic             io_fp_wb_valid,
  output logic [TAG_W-1:0] io_fp_wb_tag,
  output logic [1:0]       io_fp_wb_typeTag,
  output logic             io_fp_wb_wflags,
  output logic             io_int_wb_valid,
  output logic [TAG_W-1:0] io_int_wb_tag,
  output logic             io_int_wb_wflags,
  output logic             io_illegal,
  output logic             io_busy
);

  localparam int LAT_IDX_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
  localparam int ENTRY_W   = $bits(res_entry_t);

  fpu_class_e           cls_s;
  logic [LAT_IDX_W-1:0] lat_idx_s;
  logic                 fp_sel_s;
  logic                 int_sel_s;
  logic                 fp_slot_busy_s;
  logic                 int_slot_busy_s;
  logic                 slot_busy_s;
  logic                 accept_s;
  res_entry_t           in_entry_s;
  res_entry_t           fp_head_s;
  res_entry_t           int_head_s;
  logic                 fp_any_s;
  logic                 int_any_s;
  logic                 illegal_r;
  logic                 unused_head_bits_s;

  // Decode the class, its target port and the post-shift slot it needs
  always_comb begin
    cls_s     = sel_class(io_in_fma, io_in_fastpipe, io_in_fromint, io_in_toint);
    fp_sel_s  = 1'b0;
    int_sel_s = 1'b0;
    lat_idx_s = {LAT_IDX_W{1'b0}};
    case (cls_s)
      CLS_FMA: begin
        lat_idx_s = LAT_IDX_W'(FMA_LAT - 1);
        fp_sel_s  = 1'b1;
      end
      CLS_FPMU: begin
        lat_idx_s = LAT_IDX_W'(FPMU_LAT - 1);
        fp_sel_s  = 1'b1;
      end
      CLS_IFPU: begin
        lat_idx_s = LAT_IDX_W'(IFPU_LAT - 1);
        fp_sel_s  = 1'b1;
      end
      CLS_FPIU: begin
        lat_idx_s = LAT_IDX_W'(FPIU_LAT - 1);
        int_sel_s = 1'b1;
      end
      default: begin
        lat_idx_s = {LAT_IDX_W{1'b0}};
        fp_sel_s  = 1'b0;
        int_sel_s = 1'b0;
      end
    endcase
  end

  // Entry written for an accepted op; tag zero-extended to the shared layout
  always_comb begin
    in_entry_s              = '0;
    in_entry_s.valid        = 1'b1;
    in_entry_s.tag[TAG_W-1:0] = io_in_tag;
    in_entry_s.type_tag     = io_in_typeTagOut;
    in_entry_s.wflags       = io_in_wflags;
  end

  // NONE-class ops never wait: they reserve nothing
  assign slot_busy_s = (fp_sel_s & fp_slot_busy_s) | (int_sel_s & int_slot_busy_s);
  assign io_in_ready = ~reset & ~io_kill & ~slot_busy_s;
  assign accept_s    = io_in_valid & io_in_ready;

  wb_res_shifter #(
    .DEPTH (FMA_LAT),
    .W     (ENTRY_W),
    .IDX_W (LAT_IDX_W)
  ) u_fp_res (
    .clock      (clock),
    .reset      (reset),
    .kill       (io_kill),
    .in_en      (accept_s & fp_sel_s),
    .in_idx     (lat_idx_s),
    .in_entry   (in_entry_s),
    .query_idx  (lat_idx_s),
    .query_busy (fp_slot_busy_s),
    .head       (fp_head_s),
    .any_valid  (fp_any_s)
  );

  wb_res_shifter #(
    .DEPTH (FMA_LAT),
    .W     (ENTRY_W),
    .IDX_W (LAT_IDX_W)
  ) u_int_res (
    .clock      (clock),
    .reset      (reset),
    .kill       (io_kill),
    .in_en      (accept_s & int_sel_s),
    .in_idx     (lat_idx_s),
    .in_entry   (in_entry_s),
    .query_idx  (lat_idx_s),
    .query_busy (int_slot_busy_s),
    .head       (int_head_s),
    .any_valid  (int_any_s)
  );

  // One-cycle pulse for an accepted op that carried no class bit
  always_ff @(posedge clock) begin
    if (reset || io_kill) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= accept_s & (cls_s == CLS_NONE);
    end
  end

  assign io_fp_wb_valid   = fp_head_s.valid;
  assign io_fp_wb_tag     = fp_head_s.tag[TAG_W-1:0];
  assign io_fp_wb_typeTag = fp_head_s.type_tag;
  assign io_fp_wb_wflags  = fp_head_s.wflags;
  assign io_int_wb_valid  = int_head_s.valid;
  assign io_int_wb_tag    = int_head_s.tag[TAG_W-1:0];
  assign io_int_wb_wflags = int_head_s.wflags;
  assign io_illegal       = illegal_r;
  assign io_busy          = fp_any_s | int_any_s;

  // Upper tag bits and the INT precision field have no consumer
  assign unused_head_bits_s = ^{fp_head_s.tag, int_head_s.tag, int_head_s.type_tag};

endmodule

// File: tb/tb_fpu_wb_slot_scheduler.sv
// Directed cycle-by-cycle bench for fpu_wb_slot_scheduler with hand-computed
// expectations for reset, throughput, collisions, port independence, kill and illegal ops.
module tb_fpu_wb_slot_scheduler;

  localparam logic [3:0] C_N   = 4'b0000;
  localparam logic [3:0] C_FMA = 4'b1000;
  localparam logic [3:0] C_FP  = 4'b0100;
  localparam logic [3:0] C_FI  = 4'b0010;
  localparam logic [3:0] C_TI  = 4'b0001;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_kill;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [5:0] io_in_tag;
  logic [1:0] io_in_typeTagOut;
  logic       io_in_wflags;
  logic       io_in_fma;
  logic       io_in_fastpipe;
  logic       io_in_fromint;
  logic       io_in_toint;
  logic       io_fp_wb_valid;
  logic [5:0] io_fp_wb_tag;
  logic [1:0] io_fp_wb_typeTag;
  logic       io_fp_wb_wflags;
  logic       io_int_wb_valid;
  logic [5:0] io_int_wb_tag;
  logic       io_int_wb_wflags;
  logic       io_illegal;
  logic       io_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  fpu_wb_slot_scheduler dut (
    .clock            (clock),
    .reset            (reset),
    .io_kill          (io_kill),
    .io_in_valid      (io_in_valid),
    .io_in_ready      (io_in_ready),
    .io_in_tag        (io_in_tag),
    .io_in_typeTagOut (io_in_typeTagOut),
    .io_in_wflags     (io_in_wflags),
    .io_in_fma        (io_in_fma),
    .io_in_fastpipe   (io_in_fastpipe),
    .io_in_fromint    (io_in_fromint),
    .io_in_toint      (io_in_toint),
    .io_fp_wb_valid   (io_fp_wb_valid),
    .io_fp_wb_tag     (io_fp_wb_tag),
    .io_fp_wb_typeTag (io_fp_wb_typeTag),
    .io_fp_wb_wflags  (io_fp_wb_wflags),
    .io_int_wb_valid  (io_int_wb_valid),
    .io_int_wb_tag    (io_int_wb_tag),
    .io_int_wb_wflags (io_int_wb_wflags),
    .io_illegal       (io_illegal),
    .io_busy          (io_busy)
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One cycle: drive inputs, check outputs (rdy/busy < 0 means skip), advance
  task automatic cyc(input string nm, input logic v, input logic [5:0] tag,
                     input logic [1:0] tt, input logic wf, input logic [3:0] cls,
                     input logic kill, input int rdy,
                     input logic fv, input logic [5:0] ft, input logic [1:0] ftt,
                     input logic fwf, input logic iv, input logic [5:0] it,
                     input logic iwf, input int busy, input logic ill);
    io_in_valid      = v;
    io_in_tag        = tag;
    io_in_typeTagOut = tt;
    io_in_wflags     = wf;
    {io_in_fma, io_in_fastpipe, io_in_fromint, io_in_toint} = cls;
    io_kill          = kill;
    #1;
    if (rdy >= 0) check_eq({nm, ".ready"}, io_in_ready, rdy[0]);
    check_eq({nm, ".fp_valid"},  io_fp_wb_valid,   fv);
    check_eq({nm, ".fp_tag"},    io_fp_wb_tag,     ft);
    check_eq({nm, ".fp_type"},   io_fp_wb_typeTag, ftt);
    check_eq({nm, ".fp_wflags"}, io_fp_wb_wflags,  fwf);
    check_eq({nm, ".int_valid"}, io_int_wb_valid,  iv);
    check_eq({nm, ".int_tag"},   io_int_wb_tag,    it);
    check_eq({nm, ".int_wflags"},io_int_wb_wflags, iwf);
    check_eq({nm, ".illegal"},   io_illegal,       ill);
    if (busy >= 0) check_eq({nm, ".busy"}, io_busy, busy[0]);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    io_kill = 1'b0; io_in_valid = 1'b0; io_in_tag = 6'h00; io_in_typeTagOut = 2'd0;
    io_in_wflags = 1'b0; io_in_fma = 1'b0; io_in_fastpipe = 1'b0;
    io_in_fromint = 1'b0; io_in_toint = 1'b0;
    tick();

    // reset held with an fma offered: nothing accepted, nothing reserved
    repeat (3) cyc("rst_hold", 1'b1, 6'h05, 2'd0, 1'b0, C_FMA, 1'b0, 0, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    reset = 1'b0;
    cyc("rst_acc",  1'b1, 6'h05, 2'd0, 1'b0, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("rst_w1",   1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("rst_w2",   1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("rst_w3",   1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("rst_wb",   1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h05, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("rst_post", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // back-to-back fma, distinct precision/flags per op
    cyc("b2b_0", 1'b1, 6'h01, 2'd1, 1'b1, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("b2b_1", 1'b1, 6'h02, 2'd2, 1'b0, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("b2b_2", 1'b1, 6'h03, 2'd3, 1'b1, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("b2b_3", 1'b1, 6'h04, 2'd0, 1'b0, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("b2b_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h01, 2'd1, 1, 0, 6'h00, 0, 1, 0);
    cyc("b2b_5", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h02, 2'd2, 0, 0, 6'h00, 0, 1, 0);
    cyc("b2b_6", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h03, 2'd3, 1, 0, 6'h00, 0, 1, 0);
    cyc("b2b_7", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h04, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("b2b_8", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // fastpipe two cycles after fma wants the same slot: one-cycle stall
    cyc("col_0", 1'b1, 6'h0A, 2'd0, 1'b0, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("col_1", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("col_2", 1'b1, 6'h0B, 2'd0, 1'b0, C_FP,  1'b0, 0,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("col_3", 1'b1, 6'h0B, 2'd0, 1'b0, C_FP,  1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("col_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h0A, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("col_5", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h0B, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("col_6", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // FP and INT writebacks land in the same cycle
    cyc("ind_0", 1'b1, 6'h12, 2'd2, 1'b0, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("ind_1", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("ind_2", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("ind_3", 1'b1, 6'h11, 2'd1, 1'b1, C_TI,  1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("ind_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 1, 6'h12, 2'd2, 0, 1, 6'h11, 1, 1, 0);
    cyc("ind_5", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // latency-1 toint back to back: write to entry 0 while entry 0 retires
    cyc("l1_0", 1'b1, 6'h21, 2'd0, 1'b0, C_TI, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("l1_1", 1'b1, 6'h22, 2'd0, 1'b1, C_TI, 1'b0, 1,  0, 6'h00, 2'd0, 0, 1, 6'h21, 0, 1, 0);
    cyc("l1_2", 1'b0, 6'h00, 2'd0, 1'b0, C_N,  1'b0, -1, 0, 6'h00, 2'd0, 0, 1, 6'h22, 1, 1, 0);
    cyc("l1_3", 1'b0, 6'h00, 2'd0, 1'b0, C_N,  1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // priority: fma beats toint, fromint beats toint
    cyc("pri_0", 1'b1, 6'h15, 2'd0, 1'b0, 4'b1001, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("pri_1", 1'b1, 6'h16, 2'd0, 1'b0, 4'b0011, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("pri_2", 1'b0, 6'h00, 2'd0, 1'b0, C_N,     1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("pri_3", 1'b0, 6'h00, 2'd0, 1'b0, C_N,     1'b0, -1, 1, 6'h16, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("pri_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N,     1'b0, -1, 1, 6'h15, 2'd0, 0, 0, 6'h00, 0, -1, 0);
    cyc("pri_5", 1'b0, 6'h00, 2'd0, 1'b0, C_N,     1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // kill drops in-flight ops and refuses the op offered alongside it
    cyc("kill_0", 1'b1, 6'h07, 2'd0, 1'b0, C_FMA, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("kill_1", 1'b1, 6'h08, 2'd0, 1'b0, C_FI,  1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("kill_2", 1'b1, 6'h09, 2'd0, 1'b0, C_FMA, 1'b1, 0,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    cyc("kill_3", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("kill_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("kill_5", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("kill_6", 1'b0, 6'h00, 2'd0, 1'b0, C_N,   1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // classless op: consumed, one illegal pulse, no writeback; suppressed under kill
    cyc("ill_0", 1'b1, 6'h3F, 2'd3, 1'b1, C_N, 1'b0, 1,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("ill_1", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 1);
    cyc("ill_2", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("ill_3", 1'b1, 6'h3F, 2'd0, 1'b0, C_N, 1'b1, 0,  0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("ill_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    // reset mid-flight drops the pending fma
    cyc("mrst_0", 1'b1, 6'h2A, 2'd0, 1'b0, C_FMA, 1'b0, 1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    reset = 1'b1;
    cyc("mrst_1", 1'b1, 6'h2B, 2'd0, 1'b0, C_FMA, 1'b0, 0, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 1, 0);
    reset = 1'b0;
    cyc("mrst_2", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, 1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("mrst_3", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("mrst_4", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);
    cyc("mrst_5", 1'b0, 6'h00, 2'd0, 1'b0, C_N, 1'b0, -1, 0, 6'h00, 2'd0, 0, 0, 6'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
